// File: rtl/buffer_uart_tx_pkg.sv
// Shared types and line-level constants for the cyclic-buffer UART transmitter.
// The PARITY state exists only when BUFFER_UART_TX_PARITY_EN is defined.
package buffer_uart_tx_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam int   UART_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef BUFFER_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT-cycle period.
// clear restarts the period so a frame begins phase-aligned.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/buffer_uart_tx.sv
// Pulls bytes from the cyclic buffer read port and sends them as 8N1 UART frames on tx.
// Define BUFFER_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module buffer_uart_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 data_valid,
  input  logic [7:0]           read_data,
  output logic                 read_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  tx_state_t  state, state_next;
  logic       tick;
  logic [7:0] shift, shift_next;
  logic [2:0] bit_idx;
  logic       tx_next;
  logic       parity_bit;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == LOAD),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (enable && data_valid) state_next = LOAD;
      LOAD:  state_next = START;
      START: if (tick) state_next = DATA;
      DATA:  if (tick && bit_idx == 3'(UART_DATA_BITS - 1))
`ifdef BUFFER_UART_TX_PARITY_EN
               state_next = PARITY;
      PARITY: if (tick) state_next = STOP;
`else
               state_next = STOP;
`endif
      STOP:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is precomputed from the next state so the registered line changes on the entry edge.
  always_comb begin
    read_en    = (state == LOAD);
    busy       = (state != IDLE);
    frame_done = (state == STOP) && tick;
    shift_next = shift;
    if (state == LOAD)             shift_next = read_data;
    else if (state == DATA && tick) shift_next = shift >> 1;
    tx_next = UART_IDLE_LEVEL;
    case (state_next)
      START:  tx_next = UART_START_LEVEL;
      DATA:   tx_next = shift_next[0];
`ifdef BUFFER_UART_TX_PARITY_EN
      PARITY: tx_next = parity_bit;
`endif
      default: tx_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx          <= UART_IDLE_LEVEL;
      shift       <= '0;
      bit_idx     <= '0;
      frames_sent <= '0;
    end else begin
      tx    <= tx_next;
      shift <= shift_next;
      if (state == LOAD)              bit_idx <= '0;
      else if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (frame_done) frames_sent <= frames_sent + CNT_WIDTH'(1);
    end
  end

`ifdef BUFFER_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             parity_bit <= 1'b0;
    else if (state == LOAD) parity_bit <= ^read_data;
  end
`else
  assign parity_bit = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Directed bench for buffer_uart_tx: a cyclic-buffer model feeds the DUT and a tx line
// decoder rebuilds frames independently of the RTL.
module tb_buffer_uart_tx;

  localparam int CPB = 4;
  localparam int CW  = 16;
`ifdef BUFFER_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          data_valid = 1'b0;
  logic [7:0]    read_data = 8'h00;
  logic          read_en, tx, busy, frame_done;
  logic [CW-1:0] frames_sent;

  buffer_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .data_valid  (data_valid),
    .read_data   (read_data),
    .read_en     (read_en),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, d7..d0, start}
    logic       par;
  } vec_t;

  vec_t        vecs[6];
  int          total = 0, bad = 0;
  int          cyc_n = 0, n_re, n_fd, n_busy, n_low, fd_at;
  int          dec_pos = -1;
  logic        prev_tx = 1'b1, re_s;
  logic [10:0] frame_bits;
  logic [10:0] frames_q[$];
  int          starts_q[$];
  logic [7:0]  mem[3];
  int          len = 1, ptr = 0;
  int          exp_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_re = 0; n_fd = 0; n_busy = 0; n_low = 0; fd_at = -1;
    frames_q.delete();
    starts_q.delete();
  endtask

  task automatic load_buf(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int n);
    mem[0] = b0; mem[1] = b1; mem[2] = b2;
    len = n; ptr = 0;
    read_data = mem[0];
  endtask

  // One clock: observe at the falling edge, then advance the buffer model after the rising edge.
  task automatic cyc();
    int bitno;
    @(negedge clk);
    cyc_n++;
    if (read_en)  n_re++;
    if (busy)     n_busy++;
    if (!tx)      n_low++;
    if (dec_pos < 0) begin
      if (!tx && prev_tx) begin
        dec_pos = 0;
        frame_bits = '0;
        starts_q.push_back(cyc_n);
      end
    end else begin
      dec_pos++;
    end
    if (dec_pos >= 0 && dec_pos % CPB == CPB / 2) begin
      bitno = dec_pos / CPB;
      frame_bits[bitno] = tx;
    end
    if (frame_done) begin
      n_fd++;
      fd_at = dec_pos;
    end
    if (dec_pos == FRAME - 1) begin
      frames_q.push_back(frame_bits);
      dec_pos = -1;
    end
    prev_tx = tx;
    re_s = read_en;
    @(posedge clk);
    #1;
    if (re_s) ptr = (ptr + 1) % len;
    read_data = mem[ptr];
  endtask

  task automatic wait_frames(input int n, input int bound, input string name);
    int k = 0;
    while (frames_q.size() < n && k < bound) begin
      cyc();
      k++;
    end
    check({name, "_frame_count"}, frames_q.size(), n);
  endtask

  function automatic logic [10:0] full_frame(input vec_t v);
`ifdef BUFFER_UART_TX_PARITY_EN
    return {1'b1, v.par, v.frame[8:0]};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  initial begin
    int   t0, k;
    vec_t v;
    logic [7:0] replay_exp[5];

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[5] = '{8'h5A, 10'b1_01011010_0, 1'b0};
    replay_exp = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};

    // Reset state
    load_buf(8'h00, 8'h00, 8'h00, 1);
    clear_stats();
    repeat (3) cyc();
    check("rst_tx", tx, 1);
    check("rst_read_en", read_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frames_sent", frames_sent, 0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // Single-byte frames from the vector table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clear_stats();
      load_buf(v.data, 8'h00, 8'h00, 1);
      data_valid = 1'b1;
      enable = 1'b1;
      t0 = cyc_n;
      cyc();
      cyc();
      enable = 1'b0;
      wait_frames(1, FRAME + 10, $sformatf("vec%0d", i));
      repeat (6) cyc();
      exp_frames++;
      if (frames_q.size() > 0) begin
        check($sformatf("vec%0d_frame", i), frames_q[0], full_frame(v));
        check($sformatf("vec%0d_latency", i), starts_q[0] - t0, 3);
      end
      check($sformatf("vec%0d_read_en_count", i), n_re, 1);
      check($sformatf("vec%0d_frame_done_count", i), n_fd, 1);
      check($sformatf("vec%0d_frame_done_pos", i), fd_at, FRAME - 1);
      check($sformatf("vec%0d_frames_sent", i), frames_sent, exp_frames);
    end

    // Cyclic replay of a three-byte buffer
    clear_stats();
    load_buf(8'h11, 8'h22, 8'h33, 3);
    data_valid = 1'b1;
    enable = 1'b1;
    k = 0;
    while (n_re < 5 && k < 400) begin
      cyc();
      k++;
    end
    enable = 1'b0;
    wait_frames(5, 5 * (FRAME + 2) + 20, "replay");
    repeat (6) cyc();
    for (int i = 0; i < frames_q.size() && i < 5; i++) begin
      check($sformatf("replay_byte%0d", i), frames_q[i][8:1], replay_exp[i]);
      if (i > 0) check($sformatf("replay_gap%0d", i), starts_q[i] - starts_q[i-1], FRAME + 2);
    end
    check("replay_read_en_count", n_re, 5);
    exp_frames += 5;
    check("replay_frames_sent", frames_sent, exp_frames);

    // Empty buffer: enable alone must not start anything
    clear_stats();
    data_valid = 1'b0;
    enable = 1'b1;
    repeat (100) cyc();
    check("empty_read_en", n_re, 0);
    check("empty_tx_low", n_low, 0);
    check("empty_busy", n_busy, 0);
    enable = 1'b0;

    // Enable, data_valid and read_data all change mid-DATA: frame still completes
    clear_stats();
    load_buf(8'h3C, 8'h00, 8'h00, 1);
    data_valid = 1'b1;
    enable = 1'b1;
    k = 0;
    while (dec_pos < 2 * CPB + 1 && k < 20) begin
      cyc();
      k++;
    end
    enable = 1'b0;
    data_valid = 1'b0;
    mem[0] = 8'hFF;
    read_data = 8'hFF;
    wait_frames(1, FRAME, "drop");
    if (frames_q.size() > 0) begin
      check("drop_byte", frames_q[0][8:1], 8'h3C);
      check("drop_stop_bit", frames_q[0][NBITS-1], 1);
    end
    repeat (50) cyc();
    check("drop_read_en_count", n_re, 1);
    check("drop_frame_done_count", n_fd, 1);
    check("drop_busy_after", busy, 0);
    exp_frames++;
    check("drop_frames_sent", frames_sent, exp_frames);

    // Asynchronous reset during data bit 4 (0 for 0xA5)
    clear_stats();
    load_buf(8'hA5, 8'h00, 8'h00, 1);
    data_valid = 1'b1;
    enable = 1'b1;
    k = 0;
    while (dec_pos != 5 * CPB + 1 && k < 40) begin
      cyc();
      k++;
    end
    #2;
    check("arst_tx_before", tx, 0);
    check("arst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tx_now", tx, 1);
    check("arst_busy_now", busy, 0);
    dec_pos = -1;
    prev_tx = 1'b1;
    repeat (2) cyc();
    clear_stats();
    exp_frames = 0;
    check("arst_frames_sent", frames_sent, 0);
    rst_n = 1'b1;
    t0 = cyc_n;
    cyc();
    cyc();
    enable = 1'b0;
    wait_frames(1, FRAME + 10, "arst_restart");
    repeat (6) cyc();
    if (frames_q.size() > 0) begin
      check("arst_restart_frame", frames_q[0], full_frame(vecs[0]));
      check("arst_restart_latency", starts_q[0] - t0, 3);
    end
    check("arst_restart_read_en", n_re, 1);
    exp_frames++;
    check("arst_restart_frames_sent", frames_sent, exp_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
